// File: rtl/writeback_arbiter_if.sv
// Channel-side bundle for the writeback arbiter: NUM_CH flattened MEM/WB
// producer buses. Channel i occupies slice i of every field.
interface writeback_arbiter_if #(
   parameter int DATA_SIZE = 32,
   parameter int NUM_CH    = 2
);
   logic [NUM_CH-1:0]           in_valid;
   logic [NUM_CH-1:0]           in_ready;
   logic [6*NUM_CH-1:0]         in_op;
   logic [5*NUM_CH-1:0]         in_dest;
   logic [DATA_SIZE*NUM_CH-1:0] in_result;
   logic [DATA_SIZE*NUM_CH-1:0] in_data;
   logic [2*NUM_CH-1:0]         in_boff;

   // Producer side (pipeline channels)
   modport master (
      output in_valid, in_op, in_dest, in_result, in_data, in_boff,
      input  in_ready
   );

   // Consumer side (the arbiter)
   modport slave (
      input  in_valid, in_op, in_dest, in_result, in_data, in_boff,
      output in_ready
   );
endinterface

// File: rtl/writeback_arbiter.sv
// Multi-channel MIPS writeback stage: per-channel FIFOs filled through
// valid/ready handshakes (load data aligned/extended on the way in, stores and
// r0 writes dropped), drained round-robin onto one register-file write port.

// Per-channel FIFO holding {dest, value}. Pointers carry one extra wrap bit so
// full and empty are distinguishable without a counter.
module wb_chan_fifo #(
   parameter int DATA_SIZE = 32,
   parameter int DEPTH     = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 push,
   input  logic                 pop,
   input  logic [4:0]           push_dest,
   input  logic [DATA_SIZE-1:0] push_value,
   output logic                 empty,
   output logic                 full,
   output logic [4:0]           head_dest,
   output logic [DATA_SIZE-1:0] head_value
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   typedef struct packed {
      logic [4:0]           dest;
      logic [DATA_SIZE-1:0] value;
   } wb_entry_t;

   wb_entry_t [DEPTH-1:0] mem_q, mem_d;
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;

   assign empty      = (wr_ptr_q == rd_ptr_q);
   assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head_dest  = mem_q[rd_ptr_q[AW-1:0]].dest;
   assign head_value = mem_q[rd_ptr_q[AW-1:0]].value;

   // Next pointer/storage state; flush discards everything buffered
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q[AW-1:0]] = '{dest: push_dest, value: push_value};
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end
   end

   // Pointer registers
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Entry storage; contents are only meaningful between the pointers
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end
endmodule

module writeback_arbiter #(
   parameter  int DATA_SIZE = 32,
   parameter  int NUM_CH    = 2,
   parameter  int DEPTH     = 4,
   localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   flush,
   writeback_arbiter_if.slave     ch,
   output logic [4:0]             WB_dest,
   output logic [DATA_SIZE-1:0]   WB_value,
   output logic                   WB_WEenable,
   output logic [CH_W-1:0]        WB_ch
);
   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SW  = 6'h2b;

   // Little-endian byte/halfword pick plus sign/zero extension for loads;
   // every other opcode writes back the ALU result unchanged.
   function automatic logic [DATA_SIZE-1:0] load_align(
      input logic [5:0]           op,
      input logic [DATA_SIZE-1:0] data,
      input logic [1:0]           boff,
      input logic [DATA_SIZE-1:0] result
   );
      logic [7:0]           lane;
      logic [15:0]          half;
      logic [DATA_SIZE-1:0] v;
      case (boff)
         2'd0:    lane = data[7:0];
         2'd1:    lane = data[15:8];
         2'd2:    lane = data[23:16];
         default: lane = data[31:24];
      endcase
      half = boff[1] ? data[31:16] : data[15:0];
      case (op)
         OP_LB:   begin v = {DATA_SIZE{lane[7]}};  v[7:0]  = lane;        end
         OP_LBU:  begin v = '0;                    v[7:0]  = lane;        end
         OP_LH:   begin v = {DATA_SIZE{half[15]}}; v[15:0] = half;        end
         OP_LHU:  begin v = '0;                    v[15:0] = half;        end
         OP_LW:   begin v = {DATA_SIZE{data[31]}}; v[31:0] = data[31:0];  end
         default: v = result;
      endcase
      return v;
   endfunction

   logic [NUM_CH-1:0]                empty, full, push, pop, req;
   logic [NUM_CH-1:0][4:0]           head_dest;
   logic [NUM_CH-1:0][DATA_SIZE-1:0] head_value;
   logic [NUM_CH-1:0][DATA_SIZE-1:0] enq_value;

   logic                 gnt_vld;
   logic [CH_W-1:0]      gnt_idx;
   logic [CH_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [4:0]           wb_dest_q, wb_dest_d;
   logic [DATA_SIZE-1:0] wb_value_q, wb_value_d;
   logic                 wb_we_q, wb_we_d;
   logic [CH_W-1:0]      wb_ch_q, wb_ch_d;

   // Ready depends only on registered occupancy: a pop never frees a slot
   // for the same cycle.
   assign ch.in_ready = (reset || flush) ? '0 : ~full;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [5:0] op;
      logic [4:0] dest;
      logic       is_store;

      assign op       = ch.in_op[6*i +: 6];
      assign dest     = ch.in_dest[5*i +: 5];
      assign is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);

      // Stores and writes to r0 complete the handshake but are not buffered
      assign push[i] = ch.in_valid[i] && ch.in_ready[i] &&
                       (dest != 5'd0) && !is_store;

      assign enq_value[i] = load_align(op,
                                       ch.in_data[DATA_SIZE*i +: DATA_SIZE],
                                       ch.in_boff[2*i +: 2],
                                       ch.in_result[DATA_SIZE*i +: DATA_SIZE]);

      assign pop[i] = gnt_vld && (gnt_idx == CH_W'(i));

      wb_chan_fifo #(
         .DATA_SIZE (DATA_SIZE),
         .DEPTH     (DEPTH)
      ) u_fifo (
         .clock      (clock),
         .reset      (reset),
         .flush      (flush),
         .push       (push[i]),
         .pop        (pop[i]),
         .push_dest  (dest),
         .push_value (enq_value[i]),
         .empty      (empty[i]),
         .full       (full[i]),
         .head_dest  (head_dest[i]),
         .head_value (head_value[i])
      );
   end

   // Round-robin pick: first requester strictly after rr_ptr, else wrap to
   // the lowest requester at or below it. No grant during flush/reset.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      req     = (reset || flush) ? '0 : ~empty;
      for (int k = 0; k < NUM_CH; k++) begin
         if (!gnt_vld && req[k] && (k > int'(rr_ptr_q))) begin
            gnt_vld = 1'b1;
            gnt_idx = CH_W'(k);
         end
      end
      for (int k = 0; k < NUM_CH; k++) begin
         if (!gnt_vld && req[k] && (k <= int'(rr_ptr_q))) begin
            gnt_vld = 1'b1;
            gnt_idx = CH_W'(k);
         end
      end
   end

   // Output register and pointer update: data/channel hold when idle
   always_comb begin
      wb_we_d    = gnt_vld;
      wb_dest_d  = wb_dest_q;
      wb_value_d = wb_value_q;
      wb_ch_d    = wb_ch_q;
      rr_ptr_d   = rr_ptr_q;
      if (gnt_vld) begin
         wb_ch_d  = gnt_idx;
         rr_ptr_d = gnt_idx;
      end
      for (int k = 0; k < NUM_CH; k++) begin
         if (pop[k]) begin
            wb_dest_d  = head_dest[k];
            wb_value_d = head_value[k];
         end
      end
   end

   // State registers; rr_ptr resets to the last channel so channel 0 wins first
   always_ff @(posedge clock) begin
      if (reset) begin
         wb_we_q    <= 1'b0;
         wb_dest_q  <= '0;
         wb_value_q <= '0;
         wb_ch_q    <= '0;
         rr_ptr_q   <= CH_W'(NUM_CH - 1);
      end else begin
         wb_we_q    <= wb_we_d;
         wb_dest_q  <= wb_dest_d;
         wb_value_q <= wb_value_d;
         wb_ch_q    <= wb_ch_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

   assign WB_dest     = wb_dest_q;
   assign WB_value    = wb_value_q;
   assign WB_WEenable = wb_we_q;
   assign WB_ch       = wb_ch_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter (2 channels, depth 4, 32-bit): table of single
// loads/filters on channel 0, then round-robin, backpressure, flush and
// mid-stream reset sequences. A background scoreboard predicts every write.
module tb_writeback_arbiter;
   localparam int DS = 32;
   localparam int NC = 2;
   localparam int DP = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic          flush;
   logic [4:0]    WB_dest;
   logic [DS-1:0] WB_value;
   logic          WB_WEenable;
   logic [0:0]    WB_ch;

   writeback_arbiter_if #(.DATA_SIZE(DS), .NUM_CH(NC)) ch ();

   writeback_arbiter #(.DATA_SIZE(DS), .NUM_CH(NC), .DEPTH(DP)) dut (
      .clock       (clock),
      .reset       (reset),
      .flush       (flush),
      .ch          (ch),
      .WB_dest     (WB_dest),
      .WB_value    (WB_value),
      .WB_WEenable (WB_WEenable),
      .WB_ch       (WB_ch)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0]  dest;
      logic [31:0] value;
   } exp_t;

   exp_t        sbq0[$];
   exp_t        sbq1[$];
   logic [31:0] seen1[$];

   typedef struct {
      logic [5:0]  op;
      logic [4:0]  dest;
      logic [31:0] data;
      logic [1:0]  boff;
      logic [31:0] res;
      logic        we;
      logic [31:0] val;
   } vec_t;

   vec_t vt[13];

   task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_ch(input int c, input logic v, input logic [5:0] op, input logic [4:0] dest,
                         input logic [31:0] data, input logic [1:0] boff, input logic [31:0] res);
      ch.in_valid[c]        = v;
      ch.in_op[6*c +: 6]    = op;
      ch.in_dest[5*c +: 5]  = dest;
      ch.in_data[32*c +: 32]   = data;
      ch.in_boff[2*c +: 2]  = boff;
      ch.in_result[32*c +: 32] = res;
   endtask

   function automatic logic [31:0] model_val(input logic [5:0] op, input logic [31:0] data,
                                             input logic [1:0] boff, input logic [31:0] res);
      logic [31:0] b, h;
      b = (data >> (8 * boff)) & 32'hFF;
      h = (data >> (16 * boff[1])) & 32'hFFFF;
      case (op)
         6'h20:   return b[7] ? (b | 32'hFFFF_FF00) : b;
         6'h24:   return b;
         6'h21:   return h[15] ? (h | 32'hFFFF_0000) : h;
         6'h25:   return h;
         6'h23:   return data;
         default: return res;
      endcase
   endfunction

   function automatic bit model_drop(input logic [5:0] op, input logic [4:0] dest);
      return (dest == 5'd0) || (op == 6'h28) || (op == 6'h29) || (op == 6'h2b);
   endfunction

   // Scoreboard: at each falling edge check the current write against the
   // per-channel expectation queue, then record handshakes due at the next edge.
   task automatic monitor();
      forever begin
         @(negedge clock);
         if (WB_WEenable) begin
            exp_t e;
            bit   have;
            have = 1'b0;
            if (WB_ch == 1'b0 && sbq0.size() > 0) begin e = sbq0.pop_front(); have = 1'b1; end
            else if (WB_ch == 1'b1 && sbq1.size() > 0) begin e = sbq1.pop_front(); have = 1'b1; end
            chk(have, "sb_expected_write", 32'(WB_ch), 32'hFFFF_FFFF);
            if (have) begin
               chk(WB_dest == e.dest, "sb_dest", 32'(WB_dest), 32'(e.dest));
               chk(WB_value == e.value, "sb_value", WB_value, e.value);
            end
            if (WB_ch == 1'b1) seen1.push_back(WB_value);
         end
         if (reset || flush) begin
            sbq0.delete();
            sbq1.delete();
         end else begin
            for (int c = 0; c < NC; c++) begin
               if (ch.in_valid[c] && ch.in_ready[c] &&
                   !model_drop(ch.in_op[6*c +: 6], ch.in_dest[5*c +: 5])) begin
                  exp_t n;
                  n.dest  = ch.in_dest[5*c +: 5];
                  n.value = model_val(ch.in_op[6*c +: 6], ch.in_data[32*c +: 32],
                                      ch.in_boff[2*c +: 2], ch.in_result[32*c +: 32]);
                  if (c == 0) sbq0.push_back(n);
                  else        sbq1.push_back(n);
               end
            end
         end
      end
   endtask

   initial begin
      int  n0, n1;
      bit  r0, r1, saw_low;

      vt[0]  = '{6'h20, 5'd5,  32'h0000_80FF, 2'd1, 32'h0,         1'b1, 32'hFFFF_FF80};
      vt[1]  = '{6'h24, 5'd5,  32'h0000_80FF, 2'd1, 32'h0,         1'b1, 32'h0000_0080};
      vt[2]  = '{6'h25, 5'd6,  32'hBEEF_0000, 2'd2, 32'h0,         1'b1, 32'h0000_BEEF};
      vt[3]  = '{6'h21, 5'd7,  32'h8001_1234, 2'd3, 32'h0,         1'b1, 32'hFFFF_8001};
      vt[4]  = '{6'h23, 5'd8,  32'hDEAD_BEEF, 2'd2, 32'h0,         1'b1, 32'hDEAD_BEEF};
      vt[5]  = '{6'h00, 5'd9,  32'h0,         2'd0, 32'h1234_5678, 1'b1, 32'h1234_5678};
      vt[6]  = '{6'h2b, 5'd7,  32'h0,         2'd0, 32'h0000_0777, 1'b0, 32'h0};
      vt[7]  = '{6'h00, 5'd0,  32'h0,         2'd0, 32'h0000_1234, 1'b0, 32'h0};
      vt[8]  = '{6'h28, 5'd3,  32'hFFFF_FFFF, 2'd0, 32'h0000_0055, 1'b0, 32'h0};
      vt[9]  = '{6'h29, 5'd4,  32'h0,         2'd0, 32'h0000_0066, 1'b0, 32'h0};
      vt[10] = '{6'h20, 5'd31, 32'h0000_007F, 2'd0, 32'h0,         1'b1, 32'h0000_007F};
      vt[11] = '{6'h24, 5'd1,  32'hA500_0000, 2'd3, 32'h0,         1'b1, 32'h0000_00A5};
      vt[12] = '{6'h21, 5'd2,  32'h1234_7FFE, 2'd1, 32'h0,         1'b1, 32'h0000_7FFE};

      reset = 1'b1;
      flush = 1'b0;
      set_ch(0, 1'b0, 6'h0, 5'd0, 32'h0, 2'd0, 32'h0);
      set_ch(1, 1'b0, 6'h0, 5'd0, 32'h0, 2'd0, 32'h0);
      fork monitor(); join_none

      // Reset state
      tick();
      tick();
      chk(ch.in_ready == 2'b00, "rst_ready", 32'(ch.in_ready), 32'h0);
      chk(WB_WEenable == 1'b0, "rst_we", 32'(WB_WEenable), 32'h0);
      chk(WB_dest == 5'd0, "rst_dest", 32'(WB_dest), 32'h0);
      chk(WB_value == 32'h0, "rst_value", WB_value, 32'h0);
      chk(WB_ch == 1'b0, "rst_ch", 32'(WB_ch), 32'h0);
      reset = 1'b0;
      tick();

      // Table: single entries on channel 0, one cycle of latency after transfer
      for (int i = 0; i < 13; i++) begin
         chk(ch.in_ready[0] == 1'b1, "tbl_ready", 32'(ch.in_ready[0]), 32'h1);
         set_ch(0, 1'b1, vt[i].op, vt[i].dest, vt[i].data, vt[i].boff, vt[i].res);
         tick();
         set_ch(0, 1'b0, 6'h0, 5'd0, 32'h0, 2'd0, 32'h0);
         chk(WB_WEenable == 1'b0, "tbl_not_early", 32'(WB_WEenable), 32'h0);
         tick();
         chk(WB_WEenable == vt[i].we, "tbl_we", 32'(WB_WEenable), 32'(vt[i].we));
         if (vt[i].we) begin
            chk(WB_value == vt[i].val, "tbl_value", WB_value, vt[i].val);
            chk(WB_dest == vt[i].dest, "tbl_dest", 32'(WB_dest), 32'(vt[i].dest));
            chk(WB_ch == 1'b0, "tbl_ch", 32'(WB_ch), 32'h0);
         end
      end

      // Round robin: both channels stream 4 entries; writes alternate from ch0
      reset = 1'b1;
      tick();
      reset = 1'b0;
      set_ch(0, 1'b1, 6'h00, 5'd10, 32'h0, 2'd0, 32'hA0);
      set_ch(1, 1'b1, 6'h00, 5'd20, 32'h0, 2'd0, 32'hB0);
      for (int c = 1; c <= 9; c++) begin
         tick();
         if (c < 4) begin
            set_ch(0, 1'b1, 6'h00, 5'(10 + c), 32'h0, 2'd0, 32'hA0 + 32'(c));
            set_ch(1, 1'b1, 6'h00, 5'(20 + c), 32'h0, 2'd0, 32'hB0 + 32'(c));
         end else begin
            ch.in_valid = 2'b00;
         end
         if (c >= 2) begin
            int j;
            j = c - 2;
            chk(WB_WEenable == 1'b1, "rr_we", 32'(WB_WEenable), 32'h1);
            chk(WB_ch == 1'(j % 2), "rr_ch", 32'(WB_ch), 32'(j % 2));
            chk(WB_dest == 5'(((j % 2) != 0 ? 20 : 10) + j / 2), "rr_dest",
                32'(WB_dest), 32'(((j % 2) != 0 ? 20 : 10) + j / 2));
         end
      end
      tick();
      chk(WB_WEenable == 1'b0, "rr_idle", 32'(WB_WEenable), 32'h0);

      // Backpressure: ch1 sends values 1..10 while ch0 saturates the port
      seen1.delete();
      n0 = 0;
      n1 = 0;
      saw_low = 1'b0;
      set_ch(0, 1'b1, 6'h00, 5'd2, 32'h0, 2'd0, 32'h100);
      set_ch(1, 1'b1, 6'h00, 5'd3, 32'h0, 2'd0, 32'd1);
      for (int cyc = 0; cyc < 200 && n1 < 10; cyc++) begin
         @(negedge clock);
         r0 = ch.in_ready[0];
         r1 = ch.in_ready[1];
         if (!r1) saw_low = 1'b1;
         tick();
         if (r0) n0++;
         if (r1) n1++;
         set_ch(0, 1'b1, 6'h00, 5'd2, 32'h0, 2'd0, 32'h100 + 32'(n0));
         if (n1 < 10) set_ch(1, 1'b1, 6'h00, 5'd3, 32'h0, 2'd0, 32'(n1 + 1));
         else         ch.in_valid[1] = 1'b0;
      end
      ch.in_valid = 2'b00;
      chk(n1 == 10, "bp_transfers", 32'(n1), 32'd10);
      chk(saw_low, "bp_ready_dropped", 32'(saw_low), 32'h1);
      repeat (30) tick();
      chk(seen1.size() == 10, "bp_count", 32'(seen1.size()), 32'd10);
      for (int k = 0; k < 10 && k < seen1.size(); k++)
         chk(seen1[k] == 32'(k + 1), "bp_order", seen1[k], 32'(k + 1));

      // Flush with 3 entries buffered
      set_ch(0, 1'b1, 6'h00, 5'd14, 32'h0, 2'd0, 32'h140);
      set_ch(1, 1'b1, 6'h00, 5'd24, 32'h0, 2'd0, 32'h240);
      tick();
      set_ch(0, 1'b1, 6'h00, 5'd14, 32'h0, 2'd0, 32'h141);
      set_ch(1, 1'b1, 6'h00, 5'd24, 32'h0, 2'd0, 32'h241);
      tick();
      flush = 1'b1;
      set_ch(0, 1'b1, 6'h00, 5'd15, 32'h0, 2'd0, 32'h150);
      ch.in_valid[1] = 1'b0;
      #1;
      chk(ch.in_ready == 2'b00, "flush_ready", 32'(ch.in_ready), 32'h0);
      tick();
      flush = 1'b0;
      ch.in_valid = 2'b00;
      chk(WB_WEenable == 1'b0, "flush_we", 32'(WB_WEenable), 32'h0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk(WB_WEenable == 1'b0, "flush_no_stale", 32'(WB_WEenable), 32'h0);
      end
      set_ch(1, 1'b1, 6'h00, 5'd25, 32'h0, 2'd0, 32'h5555);
      tick();
      ch.in_valid = 2'b00;
      chk(WB_WEenable == 1'b0, "flush_new_early", 32'(WB_WEenable), 32'h0);
      tick();
      chk(WB_WEenable == 1'b1, "flush_new_we", 32'(WB_WEenable), 32'h1);
      chk(WB_dest == 5'd25, "flush_new_dest", 32'(WB_dest), 32'd25);
      chk(WB_value == 32'h5555, "flush_new_value", WB_value, 32'h5555);
      chk(WB_ch == 1'b1, "flush_new_ch", 32'(WB_ch), 32'h1);

      // Reset mid-stream
      for (int k = 0; k < 3; k++) begin
         set_ch(0, 1'b1, 6'h00, 5'd16, 32'h0, 2'd0, 32'h160 + 32'(k));
         set_ch(1, 1'b1, 6'h00, 5'd26, 32'h0, 2'd0, 32'h260 + 32'(k));
         tick();
      end
      reset = 1'b1;
      #1;
      chk(ch.in_ready == 2'b00, "mrst_ready_now", 32'(ch.in_ready), 32'h0);
      for (int k = 0; k < 2; k++) begin
         tick();
         chk(ch.in_ready == 2'b00, "mrst_ready", 32'(ch.in_ready), 32'h0);
         chk(WB_WEenable == 1'b0, "mrst_we", 32'(WB_WEenable), 32'h0);
         chk(WB_dest == 5'd0, "mrst_dest", 32'(WB_dest), 32'h0);
         chk(WB_value == 32'h0, "mrst_value", WB_value, 32'h0);
      end
      reset = 1'b0;
      ch.in_valid = 2'b00;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk(WB_WEenable == 1'b0, "mrst_no_stale", 32'(WB_WEenable), 32'h0);
      end

      chk(sbq0.size() == 0 && sbq1.size() == 0, "sb_drained",
          32'(sbq0.size() + sbq1.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
